// File: rtl/sht30_measure_ctrl_if.sv
// sht30_measure_ctrl_if: byte-level I2C op request/response channel (cmd_* requests, rsp_* completions)
interface sht30_measure_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_nack;
  modport master(output cmd_valid, cmd_op, cmd_data, input cmd_ready, rsp_valid, rsp_data, rsp_nack);
  modport slave(input cmd_valid, cmd_op, cmd_data, output cmd_ready, rsp_valid, rsp_data, rsp_nack);
endinterface

// File: rtl/sht30_measure_ctrl.sv
// sht30_measure_ctrl: SHT30 single-shot sequencer (clk_50M/rst, start/auto_en triggers, bus op channel, busy, raw words, data/error strobes)
module sht30_measure_ctrl #(
  parameter logic [6:0]  I2C_ADDR      = 7'h44,
  parameter logic [15:0] MEAS_CMD      = 16'h2400,
  parameter int          WAIT_CYCLES   = 800000,
  parameter int          PERIOD_CYCLES = 50000000,
  parameter int          RSP_TIMEOUT   = 100000
) (
  input  logic                        clk_50M,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        auto_en,
  sht30_measure_ctrl_if.master        bus,
  output logic                        busy,
  output logic [15:0]                 temp_raw,
  output logic [15:0]                 hum_raw,
  output logic                        data_valid,
  output logic                        crc_err,
  output logic                        nack_err,
  output logic                        timeout_err
);
  typedef enum logic [3:0] {IDLE, W_START, W_ADDR, W_CMDH, W_CMDL, W_STOP, WAIT, R_START, R_ADDR, R_BYTE, R_STOP, ABORT_STOP, DONE} state_t;
  localparam logic [2:0] OP_START = 3'd0, OP_WRITE = 3'd1, OP_RDA = 3'd2, OP_RDN = 3'd3, OP_STOP = 3'd4;
  state_t state, nxt;
  logic [2:0] idx, op;
  logic [7:0] wdata;
  logic [31:0] tmr, pcnt;
  logic [47:0] rbuf;
  logic out, is_wr, period_hit, crc_ok;
  function automatic logic [7:0] crc8(input logic [15:0] w);
    logic [7:0] c;
    c = 8'hFF;
    for (int i = 15; i >= 0; i--) c = (c[7] ^ w[i]) ? {c[6:0], 1'b0} ^ 8'h31 : {c[6:0], 1'b0};
    return c;
  endfunction
  assign busy = state != IDLE;
  assign period_hit = auto_en && pcnt == 32'(PERIOD_CYCLES - 1);
  assign is_wr = state == W_ADDR || state == W_CMDH || state == W_CMDL || state == R_ADDR;
  assign crc_ok = crc8(rbuf[47:32]) == rbuf[31:24] && crc8(rbuf[23:8]) == rbuf[7:0];
  always_comb begin
    op = (state == W_START || state == R_START) ? OP_START :
         (state == W_STOP || state == R_STOP || state == ABORT_STOP) ? OP_STOP :
         (state == R_BYTE) ? (idx == 3'd5 ? OP_RDN : OP_RDA) : OP_WRITE;
    wdata = state == W_ADDR ? {I2C_ADDR, 1'b0} :
            state == W_CMDH ? MEAS_CMD[15:8] :
            state == W_CMDL ? MEAS_CMD[7:0] :
            state == R_ADDR ? {I2C_ADDR, 1'b1} : 8'h00;
  end
  always_comb begin
    nxt = IDLE;
    case (state)
      W_START: nxt = W_ADDR;
      W_ADDR:  nxt = W_CMDH;
      W_CMDH:  nxt = W_CMDL;
      W_CMDL:  nxt = W_STOP;
      W_STOP:  nxt = WAIT;
      R_START: nxt = R_ADDR;
      R_ADDR:  nxt = R_BYTE;
      R_BYTE:  nxt = idx == 3'd5 ? R_STOP : R_BYTE;
      default: nxt = DONE;
    endcase
  end
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      out <= 1'b0;
      tmr <= '0;
      pcnt <= '0;
      rbuf <= '0;
      bus.cmd_valid <= 1'b0;
      bus.cmd_op <= '0;
      bus.cmd_data <= '0;
      temp_raw <= '0;
      hum_raw <= '0;
      data_valid <= 1'b0;
      crc_err <= 1'b0;
      nack_err <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      crc_err <= 1'b0;
      nack_err <= 1'b0;
      timeout_err <= 1'b0;
      if (auto_en) pcnt <= period_hit ? '0 : pcnt + 32'd1;
      if (state == IDLE) begin
        if (start || period_hit) begin
          state <= W_START;
          idx <= '0;
        end
      end else if (state == WAIT) begin
        tmr <= tmr + 32'd1;
        if (tmr == 32'(WAIT_CYCLES - 1)) state <= R_START;
      end else if (state == DONE) begin
        state <= IDLE;
      end else if (!out && !bus.cmd_valid) begin
        bus.cmd_valid <= 1'b1;
        bus.cmd_op <= op;
        bus.cmd_data <= wdata;
      end else if (bus.cmd_valid) begin
        if (bus.cmd_ready) begin
          bus.cmd_valid <= 1'b0;
          out <= 1'b1;
          tmr <= '0;
        end
      end else if (bus.rsp_valid) begin
        out <= 1'b0;
        tmr <= '0;
        if (is_wr && bus.rsp_nack) state <= ABORT_STOP;
        else begin
          state <= nxt;
          if (state == R_BYTE) begin
            rbuf <= {rbuf[39:0], bus.rsp_data};
            idx <= idx + 3'd1;
          end
          if (state == R_STOP) begin
            if (crc_ok) begin
              temp_raw <= rbuf[47:32];
              hum_raw <= rbuf[23:8];
              data_valid <= 1'b1;
            end else crc_err <= 1'b1;
          end
          if (state == ABORT_STOP) nack_err <= 1'b1;
        end
      end else if (tmr == 32'(RSP_TIMEOUT - 1)) begin
        out <= 1'b0;
        timeout_err <= 1'b1;
        state <= DONE;
      end else tmr <= tmr + 32'd1;
    end
  end
endmodule
